// File: rtl/swervolf_gpio_pkg.sv
// Shared constants for the SweRVolf slide-switch GPIO front end.
package swervolf_gpio_pkg;

    localparam int SW_WIDTH         = 16;
    localparam int SW_SYNC_STAGES   = 2;
    localparam int SW_DEBOUNCE_10MS = 500000;

    function automatic int cnt_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/swervolf_debounce_bit.sv
// One switch channel: synchroniser chain, stability counter, debounced level
// and registered rise/fall pulses.
module swervolf_debounce_bit
    import swervolf_gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_10MS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // A single cycle where the synchronised input agrees with the level restarts the window.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_sw};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_sw   = level_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/swervolf_sw_debounce.sv
// Debounced slide-switch bank with sticky change flags and a combined interrupt,
// feeding the upper half of the core GPIO input.
module swervolf_sw_debounce
    import swervolf_gpio_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_10MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_sw_rise,
    output logic [WIDTH-1:0] o_sw_fall,
    output logic [WIDTH-1:0] o_pending,
    input  logic [WIDTH-1:0] i_pend_clr,
    output logic             o_irq
);

    logic [WIDTH-1:0] pending_q, pending_d;
    logic             irq_q, irq_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        swervolf_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .i_sw   (i_sw[g]),
            .o_sw   (o_sw[g]),
            .o_rise (o_sw_rise[g]),
            .o_fall (o_sw_fall[g])
        );
    end

    // New events are OR-ed in after the clear so a coincident clear cannot lose them.
    always_comb begin
        pending_d = (pending_q & ~i_pend_clr) | o_sw_rise | o_sw_fall;
        irq_d     = |pending_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign o_pending = pending_q;
    assign o_irq     = irq_q;

endmodule

// File: tb/tb_swervolf_sw_debounce.sv
// Directed and randomised checks of the switch debouncer against a window-based
// reference model of the synchronised input history.
module tb_swervolf_sw_debounce;

    localparam int W  = 16;
    localparam int SS = 2;
    localparam int DC = 8;
    localparam int HL = SS + DC;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_sw;
    logic [W-1:0] i_pend_clr;
    logic [W-1:0] o_sw, o_sw_rise, o_sw_fall, o_pending;
    logic         o_irq;

    int total = 0;
    int bad   = 0;

    // hist[k] holds the raw input captured k edges ago (zero while in reset).
    logic [W-1:0] hist [HL];
    logic [W-1:0] exp_sw, exp_rise, exp_fall, exp_pend;
    logic         exp_irq;

    swervolf_sw_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_sw       (i_sw),
        .o_sw       (o_sw),
        .o_sw_rise  (o_sw_rise),
        .o_sw_fall  (o_sw_fall),
        .o_pending  (o_pending),
        .i_pend_clr (i_pend_clr),
        .o_irq      (o_irq)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // A level flips once the last DC synchronised samples all disagree with it.
    task automatic model_edge();
        logic [W-1:0] nsw, nrise, nfall, npend;
        logic         flip;
        for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = rst ? '0 : i_sw;
        if (rst) begin
            for (int j = 0; j < HL; j++) hist[j] = '0;
            exp_sw = '0; exp_rise = '0; exp_fall = '0; exp_pend = '0; exp_irq = 1'b0;
        end else begin
            npend = (exp_pend & ~i_pend_clr) | exp_rise | exp_fall;
            nsw = exp_sw; nrise = '0; nfall = '0;
            for (int b = 0; b < W; b++) begin
                flip = 1'b1;
                for (int i = 0; i < DC; i++)
                    if (hist[SS+i][b] == exp_sw[b]) flip = 1'b0;
                if (flip) begin
                    nsw[b]   = ~exp_sw[b];
                    nrise[b] = ~exp_sw[b];
                    nfall[b] = exp_sw[b];
                end
            end
            exp_sw = nsw; exp_rise = nrise; exp_fall = nfall;
            exp_pend = npend; exp_irq = |npend;
        end
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_output("sw",      o_sw,      exp_sw);
            check_output("rise",    o_sw_rise, exp_rise);
            check_output("fall",    o_sw_fall, exp_fall);
            check_output("pending", o_pending, exp_pend);
            check_output("irq",     W'(o_irq), W'(exp_irq));
        end
    endtask

    initial begin
        int first;
        int rises;
        bit found;

        for (int j = 0; j < HL; j++) hist[j] = '0;
        exp_sw = '0; exp_rise = '0; exp_fall = '0; exp_pend = '0; exp_irq = 1'b0;
        rst = 1'b1; i_sw = '0; i_pend_clr = '0;

        // Reset and quiet inputs.
        apply_stimulus(3);
        rst = 1'b0;
        apply_stimulus(20);
        check_output("t1_sw_idle", o_sw, 16'h0000);

        // Single clean rise on bit 3.
        i_sw[3] = 1'b1;
        first = 0; rises = 0;
        for (int e = 1; e <= 14; e++) begin
            apply_stimulus(1);
            if (o_sw[3] && first == 0) first = e;
            if (o_sw_rise[3]) rises++;
        end
        check_output("t2_edge",    W'(first), W'(10));
        check_output("t2_rises",   W'(rises), W'(1));
        check_output("t2_pending", o_pending, 16'h0008);
        check_output("t2_irq",     W'(o_irq), W'(1));

        // Short pulse on bit 5 is rejected.
        i_sw[5] = 1'b1;
        apply_stimulus(7);
        i_sw[5] = 1'b0;
        apply_stimulus(15);
        check_output("t3_sw5",   W'(o_sw[5]),      W'(0));
        check_output("t3_pend5", W'(o_pending[5]), W'(0));

        // Chatter on bit 0, then a settled high.
        for (int p = 0; p < 10; p++) begin
            i_sw[0] = ~i_sw[0];
            apply_stimulus(3);
        end
        check_output("t4_sw0_chatter", W'(o_sw[0]), W'(0));
        i_sw[0] = 1'b1;
        first = 0; rises = 0;
        for (int e = 1; e <= 14; e++) begin
            apply_stimulus(1);
            if (o_sw[0] && first == 0) first = e;
            if (o_sw_rise[0]) rises++;
        end
        check_output("t4_edge",  W'(first), W'(10));
        check_output("t4_rises", W'(rises), W'(1));

        // Clear racing a new fall event on bit 3: the set wins.
        i_pend_clr = 16'h0001;
        apply_stimulus(1);
        i_pend_clr = '0;
        i_sw[3] = 1'b0;
        found = 1'b0;
        for (int e = 0; e < 20 && !found; e++) begin
            apply_stimulus(1);
            if (o_sw_fall[3]) found = 1'b1;
        end
        check_output("t5_fall_seen", W'(found), W'(1));
        i_pend_clr = 16'h0008;
        apply_stimulus(1);
        check_output("t5_set_wins", W'(o_pending[3]), W'(1));
        apply_stimulus(1);
        i_pend_clr = '0;
        check_output("t5_cleared", o_pending, 16'h0000);
        check_output("t5_irq_low", W'(o_irq), W'(0));

        // Reset in the middle of a debounce window on bit 7.
        i_sw[7] = 1'b1;
        apply_stimulus(7);
        rst = 1'b1;
        apply_stimulus(1);
        rst = 1'b0;
        check_output("t6_sw7_reset", W'(o_sw[7]), W'(0));
        first = 0; rises = 0;
        for (int e = 1; e <= 14; e++) begin
            apply_stimulus(1);
            if (o_sw_rise[7] && first == 0) first = e;
            if (o_sw_rise[7]) rises++;
        end
        check_output("t6_edge",  W'(first), W'(10));
        check_output("t6_rises", W'(rises), W'(1));

        // Random activity on all channels with sparse clears and resets.
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 9) == 0) i_sw[b] = ~i_sw[b];
            i_pend_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            rst = ($urandom_range(0, 249) == 0);
            apply_stimulus(1);
        end
        rst = 1'b0;
        i_pend_clr = '0;
        apply_stimulus(HL + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
